accum_seq: RTL
==============

ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 SHALL have one clock, Clock; reset is synchronous and active-low, Resetn.
REQ-002 Clock  input  1  rising-edge system clock.
REQ-003 Resetn  input  1  synchronous active-low reset, sampled on rising Clock.
REQ-004 X  input  3  unsigned operand.
REQ-005 Start  input  1  request a new accumulation run; honoured only in IDLE.
REQ-006 Count  input  2  operands in run; sampled with Start; 0 means 4.
REQ-007 Valid  input  1  X holds an operand.
REQ-008 Ready  output  1  block accepts an operand this cycle.
REQ-009 Busy  output  1  high in every state except IDLE.
REQ-010 Done  output  1  one-cycle pulse at run completion.
REQ-011 Acc  output  3  running sum modulo 8.
REQ-012 Ovf  output  1  sticky carry-out flag for the current run.
REQ-013 leds  output  [1:7]  7-segment digit, segments a..g, active-low.

Function
REQ-014 SHALL implement FSM states IDLE, ACCEPT, DONE; all outputs registered except leds and Ready/Busy/Done, which decode from state.
REQ-015 IDLE: Ready=0, Busy=0, Done=0; Start=1 -> load remaining count (Count, or 4 if Count=0), clear Acc and Ovf, go ACCEPT next edge.
REQ-016 ACCEPT: Ready=1; operand accepted only on an edge where Valid=1 and Ready=1.
REQ-017 On acceptance: {c, Acc} <= Acc + X (4-bit sum); Ovf <= Ovf | c; remaining count decrements; new Acc/Ovf visible the cycle after the accepting edge.
REQ-018 Acceptance of the final operand SHALL move to DONE; otherwise stay in ACCEPT.
REQ-019 Valid=0 in ACCEPT SHALL hold all state; no timeout.
REQ-020 DONE: Done=1, Busy=1, Ready=0 for exactly one cycle, then IDLE unconditionally.
REQ-021 Acc and Ovf SHALL hold their final values in IDLE until the next accepted Start.
REQ-022 Start in ACCEPT or DONE SHALL be ignored; Valid outside ACCEPT SHALL be ignored.
REQ-023 Start and Valid both high in IDLE: only Start acts; the operand is not accepted.
REQ-024 leds SHALL display the hex digit of {Ovf, Acc}; patterns 0=0000001, 4=1001100, 6=0100000, E=0110000, full 0..F table standard.

Reset
REQ-025 Resetn=0 at a rising edge SHALL force IDLE, Acc=0, Ovf=0, remaining count=0; it overrides Start/Valid.
REQ-026 Reset mid-run SHALL abandon the run with no Done pulse.
REQ-027 After reset leds SHALL show 0 (0000001).

Structure
REQ-028 State encodings, operand width (3), and count width (2) SHALL be constants in the shared package.
REQ-029 The hex-to-7-segment decoder SHALL be a separate sub-module, hex7seg, 4-bit in, [1:7] out.
REQ-030 Adder SHALL be 3-bit with carry-out, inline or as the existing ripple-adder sub-module.

Verification
REQ-031 Start, Count=3; X=2,3,1 with Valid each -> Acc=6, Ovf=0, Done one cycle after third accept, leds=0100000.
REQ-032 Count=2; X=7,7 -> Acc=6, Ovf=1, leds=0110000 (E).
REQ-033 Count=0; X=1 four times -> exactly four accepts, Acc=4, leds=1001100; fifth Valid ignored.
REQ-034 Resetn=0 after second accept of a Count=3 run -> IDLE, Acc=0, Ovf=0, no Done, leds=0000001.
REQ-035 Start pulsed in ACCEPT; Valid held with Start in IDLE -> neither alters count nor Acc.
REQ-036 Valid deasserted for 5 cycles mid-run -> Acc/count unchanged, Ready stays 1, run completes normally.

Source files
------------

// File: rtl/accum_seq_pkg.sv
// Shared constants and types for the accumulate-and-display sequencer.
package accum_seq_pkg;

    localparam int OPND_W = 3;
    localparam int CNT_W  = 2;
    // One extra bit so a Count of zero can stand for a full run of 2**CNT_W operands.
    localparam int REM_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [REM_W-1:0] load_count(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? REM_W'(1 << CNT_W) : {1'b0, cnt};
    endfunction

endpackage

// File: rtl/accum_seq_if.sv
// Operand handshake, run control and result bus of the accumulate sequencer.
interface accum_seq_if;
    import accum_seq_pkg::*;

    logic [OPND_W-1:0] X;
    logic              Start;
    logic [CNT_W-1:0]  Count;
    logic              Valid;
    logic              Ready;
    logic              Busy;
    logic              Done;
    logic [OPND_W-1:0] Acc;
    logic              Ovf;
    logic [1:7]        leds;

    modport master (
        output X, Start, Count, Valid,
        input  Ready, Busy, Done, Acc, Ovf, leds
    );

    modport slave (
        input  X, Start, Count, Valid,
        output Ready, Busy, Done, Acc, Ovf, leds
    );

endinterface

// File: rtl/hex7seg.sv
// Hex digit to active-low 7-segment pattern, segments a..g on bits 1..7.
// Latency: combinational.
// Backpressure: none.
module hex7seg (
    input  logic [3:0] hex,
    output logic [1:7] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/accum_seq.sv
// Accumulates a run of Count operands modulo 8 with sticky carry, shows {Ovf,Acc} on a 7-seg digit.
// Latency: sum visible one cycle after the accepting edge; Done one cycle after the last accept.
// Backpressure: Ready high only in ACCEPT; Valid elsewhere is dropped, Valid low just stalls the run.
module accum_seq
    import accum_seq_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    accum_seq_if.slave  bus
);

    state_t            state_q, state_d;
    logic [OPND_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              accept;
    logic [OPND_W:0]   sum;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            rem_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            rem_q <= rem_d;
        end
    end

    assign accept = (state_q == ST_ACCEPT) && bus.Valid;
    assign sum    = {1'b0, acc_q} + {1'b0, bus.X};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.Start) state_d = ST_ACCEPT;
            ST_ACCEPT: if (accept && rem_q == REM_W'(1)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.Ready = (state_q == ST_ACCEPT);
        bus.Busy  = (state_q != ST_IDLE);
        bus.Done  = (state_q == ST_DONE);
    end

    // Start in IDLE takes priority; Valid is only meaningful in ACCEPT.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        rem_d = rem_q;
        if (state_q == ST_IDLE && bus.Start) begin
            acc_d = '0;
            ovf_d = 1'b0;
            rem_d = load_count(bus.Count);
        end else if (accept) begin
            acc_d = sum[OPND_W-1:0];
            ovf_d = ovf_q | sum[OPND_W];
            rem_d = rem_q - REM_W'(1);
        end
    end

    assign bus.Acc = acc_q;
    assign bus.Ovf = ovf_q;

    hex7seg u_hex7seg (
        .hex ({ovf_q, acc_q}),
        .seg (bus.leds)
    );

endmodule
